bsg_cgol_grid: RTL and testbench
================================

// Module: bsg_cgol_grid
// PURPOSE
//  Parametrised Game-of-Life engine: height_p x width_p cell array, all cells
//  stepped in parallel once per cycle. Adds row-serial board loading, a
//  programmable birth/survive rule (any B/S life-like rule), torus or
//  dead-edge boundaries, and a run controller.
//  The run controller executes N generations, counts them, and stops early
//  on a still-life. Sits between the host load/command interface and the
//  display readout.
// PARAMETERS
//  width_p      8   columns per row
//  height_p     8   rows
//  gen_width_p  16  width of the generation counter and of num_gens_i
//  wrap_p       1   1: toroidal edges; 0: out-of-range neighbours read as dead
// PORTS
//  clk_i           in   1                  clock
//  reset_i         in   1                  async, active-high reset
//  load_v_i        in   1                  write load_row_i into row at the load pointer
//  load_row_i      in   width_p            row data; bit c = column c
//  start_v_i       in   1                  start a run (accepted only when ready_o=1)
//  num_gens_i      in   gen_width_p        number of generations to run
//  birth_mask_i    in   9                  bit k=1: dead cell with k live neighbours is born
//  survive_mask_i  in   9                  bit k=1: live cell with k live neighbours survives
//  ready_o         out  1                  1 in IDLE only
//  done_o          out  1                  one-cycle pulse when a run ends
//  stable_o        out  1                  last run ended on an unchanged generation
//  gen_count_o     out  gen_width_p        generations committed in current/last run
//  board_o         out  width_p*height_p   cell state; bit r*width_p+c = row r, col c
// BEHAVIOUR
//  Reset (async, any state, including mid-run):
//   - board_o=0, load pointer=0, state=IDLE, done_o=0, stable_o=0, gen_count_o=0.
//   - ready_o=1 while reset_i is deasserted in IDLE.
//  FSM states:
//   - IDLE: ready_o=1.
//     - load_v_i: row[ptr] <= load_row_i; ptr wraps height_p-1 -> 0.
//     - start_v_i: latch masks and num_gens_i; clear gen_count and stable;
//       go RUN (or DONE if num_gens_i=0).
//     - load_v_i and start_v_i together: row is written and the run starts;
//       the first generation uses the updated board.
//     - Load pointer is untouched by start.
//   - RUN: every cycle commit next board, gen_count+1.
//     - If next board == current board: set stable_o, go DONE.
//     - Else if gen_count+1 == latched N: go DONE.
//     - load_v_i and start_v_i are ignored; mask inputs are ignored (latched copies used).
//   - DONE: done_o=1 for exactly this cycle; return to IDLE; outputs hold.
//  Latency:
//   - Start accepted at edge T; generation k is committed at edge T+k.
//   - done_o is high in the cycle after the last commit.
//   - N=0: done_o is high in the cycle after acceptance, board unchanged, gen_count=0.
//  Cell rule:
//   - n = popcount of 8 neighbours (0..8, 4 bits).
//   - next = alive ? survive_mask[n] : birth_mask[n].
//  Edges:
//   - wrap_p=1: row/col indices taken modulo height_p/width_p.
//   - Corners wrap diagonally.
//   - width_p or height_p of 1 or 2 aliases neighbours (counted with multiplicity).
//  gen_count saturates at 2^gen_width_p-1 (never wraps).
//  board_o, gen_count_o and stable_o are registered; no combinational input->output paths.
// TESTING
//  1 Reset: assert reset_i mid-RUN, async to clk
//     -> board_o=0, ready_o=1, gen_count_o=0 immediately, no done_o pulse.
//  2 Blinker on 8x8, wrap_p=0: rows 3..5 col 4 live; B3/S23 (birth 9'h008, survive 9'h00C); N=2
//     -> after gen 1 row 4 cols 3..5 live; after gen 2 original board.
//     -> done_o pulses at T+3, gen_count_o=2, stable_o=0.
//  3 Still life: 2x2 block at (2,2); N=10
//     -> stops after gen 1, gen_count_o=1, stable_o=1, board unchanged.
//  4 Torus: glider on 8x8, wrap_p=1, B3/S23, N=32
//     -> final board equals initial board, gen_count_o=32, stable_o=0.
//  5 N=0 with simultaneous load_v_i (row 0 = 8'hA5)
//     -> row 0 = 8'hA5, done_o in next cycle, gen_count_o=0.
//  6 Load wrap: 9 consecutive loads on height_p=8
//     -> row 0 holds the 9th value, rows 1..7 hold values 2..8.
//     -> load/start during RUN change nothing.

Source files
------------

// File: rtl/bsg_cgol_grid.sv
// Game-of-Life engine: height_p x width_p torus or dead-edge board, row-serial loading,
// programmable B/S rule and a run controller that stops after N generations or on a still life.
module bsg_cgol_grid #(
  parameter int width_p     = 8,
  parameter int height_p    = 8,
  parameter int gen_width_p = 16,
  parameter bit wrap_p      = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            load_v_i,
  input  logic [width_p-1:0]              load_row_i,
  input  logic                            start_v_i,
  input  logic [gen_width_p-1:0]          num_gens_i,
  input  logic [8:0]                      birth_mask_i,
  input  logic [8:0]                      survive_mask_i,
  output logic                            ready_o,
  output logic                            done_o,
  output logic                            stable_o,
  output logic [gen_width_p-1:0]          gen_count_o,
  output logic [width_p*height_p-1:0]     board_o
);

  localparam int ptr_w_lp = (height_p > 1) ? $clog2(height_p) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                               state_q, state_d;
  logic [height_p-1:0][width_p-1:0]     board_q, board_d, life_next;
  logic [ptr_w_lp-1:0]                  ptr_q, ptr_d;
  logic [gen_width_p-1:0]               gen_q, gen_d, num_q, num_d;
  logic [8:0]                           birth_q, birth_d, survive_q, survive_d;
  logic                                 stable_q, stable_d;
  logic [gen_width_p:0]                 gen_plus;

  // Board surrounded by a one-cell halo: wrapped copies on a torus, zeros otherwise.
  // Small boards alias the same source cell several times, which is intended.
  logic [height_p+1:0][width_p+1:0]     pad;

  for (genvar r = 0; r < height_p + 2; r++) begin : g_pad_r
    for (genvar c = 0; c < width_p + 2; c++) begin : g_pad_c
      localparam int src_r_lp = (r + height_p - 1) % height_p;
      localparam int src_c_lp = (c + width_p - 1) % width_p;
      localparam bit halo_lp  = (r == 0) || (r == height_p + 1) || (c == 0) || (c == width_p + 1);
      if (!wrap_p && halo_lp) begin : g_dead
        assign pad[r][c] = 1'b0;
      end else begin : g_live
        assign pad[r][c] = board_q[src_r_lp][src_c_lp];
      end
    end
  end

  for (genvar r = 0; r < height_p; r++) begin : g_cell_r
    for (genvar c = 0; c < width_p; c++) begin : g_cell_c
      logic [3:0] nbr;
      assign nbr = 4'(pad[r][c])     + 4'(pad[r][c+1])   + 4'(pad[r][c+2])
                 + 4'(pad[r+1][c])                       + 4'(pad[r+1][c+2])
                 + 4'(pad[r+2][c])   + 4'(pad[r+2][c+1]) + 4'(pad[r+2][c+2]);
      assign life_next[r][c] = board_q[r][c] ? survive_q[nbr] : birth_q[nbr];
    end
  end

  assign gen_plus = {1'b0, gen_q} + (gen_width_p+1)'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    board_d   = board_q;
    ptr_d     = ptr_q;
    gen_d     = gen_q;
    num_d     = num_q;
    birth_d   = birth_q;
    survive_d = survive_q;
    stable_d  = stable_q;
    unique case (state_q)
      IDLE: begin
        if (load_v_i) begin
          board_d[ptr_q] = load_row_i;
          ptr_d = (ptr_q == ptr_w_lp'(height_p - 1)) ? '0 : ptr_q + ptr_w_lp'(1);
        end
        if (start_v_i) begin
          birth_d   = birth_mask_i;
          survive_d = survive_mask_i;
          num_d     = num_gens_i;
          gen_d     = '0;
          stable_d  = 1'b0;
          state_d   = (num_gens_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        board_d = life_next;
        gen_d   = (&gen_q) ? gen_q : gen_plus[gen_width_p-1:0];
        if (life_next == board_q) begin
          stable_d = 1'b1;
          state_d  = DONE;
        end else if (gen_plus == {1'b0, num_q}) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the board array is reset too, because a cleared board is visible on board_o.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      board_q   <= '0;
      ptr_q     <= '0;
      gen_q     <= '0;
      num_q     <= '0;
      birth_q   <= '0;
      survive_q <= '0;
      stable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      ptr_q     <= ptr_d;
      gen_q     <= gen_d;
      num_q     <= num_d;
      birth_q   <= birth_d;
      survive_q <= survive_d;
      stable_q  <= stable_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign done_o      = (state_q == DONE);
  assign stable_o    = stable_q;
  assign gen_count_o = gen_q;
  assign board_o     = board_q;

endmodule

// File: tb/tb_bsg_cgol_grid.sv
// Scoreboard bench: a dead-edge and a torus instance share stimulus; a grid-level Life model
// predicts each run's final board, generation count, stability and done cycle.
module tb_bsg_cgol_grid;
  localparam int W = 8;
  localparam int H = 8;
  localparam int G = 16;
  localparam logic [8:0] B3  = 9'h008;
  localparam logic [8:0] S23 = 9'h00C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_i, load_v, start_v;
  logic [W-1:0]   load_row;
  logic [G-1:0]   num_gens;
  logic [8:0]     bmask, smask;
  logic           ready [2];
  logic           done  [2];
  logic           stable[2];
  logic [G-1:0]   gen   [2];
  logic [W*H-1:0] board [2];

  bsg_cgol_grid #(.width_p(W), .height_p(H), .gen_width_p(G), .wrap_p(1'b0)) dut_flat (
    .clk_i(clk), .reset_i(reset_i), .load_v_i(load_v), .load_row_i(load_row),
    .start_v_i(start_v), .num_gens_i(num_gens), .birth_mask_i(bmask), .survive_mask_i(smask),
    .ready_o(ready[0]), .done_o(done[0]), .stable_o(stable[0]), .gen_count_o(gen[0]),
    .board_o(board[0]));

  bsg_cgol_grid #(.width_p(W), .height_p(H), .gen_width_p(G), .wrap_p(1'b1)) dut_torus (
    .clk_i(clk), .reset_i(reset_i), .load_v_i(load_v), .load_row_i(load_row),
    .start_v_i(start_v), .num_gens_i(num_gens), .birth_mask_i(bmask), .survive_mask_i(smask),
    .ready_o(ready[1]), .done_o(done[1]), .stable_o(stable[1]), .gen_count_o(gen[1]),
    .board_o(board[1]));

  typedef struct {
    logic [W*H-1:0] board;
    logic [G-1:0]   gen;
    logic           stable;
    int unsigned    cyc;
  } exp_t;

  exp_t           sb[2][$];
  logic [W*H-1:0] mb[2];
  int             mptr;
  int             vectors = 0;
  int             miscompares = 0;
  int unsigned    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain cell-by-cell Life on a 2D index space.
  function automatic logic [W*H-1:0] model_step(input logic [W*H-1:0] cur, input bit wrap,
                                               input logic [8:0] bm, input logic [8:0] sm);
    logic [W*H-1:0] nxt;
    int n, rr, cc;
    nxt = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
              continue;
            end
            n += int'(cur[rr*W + cc]);
          end
        end
        nxt[r*W + c] = cur[r*W + c] ? sm[n] : bm[n];
      end
    end
    return nxt;
  endfunction

  function automatic exp_t model_run(input logic [W*H-1:0] cur, input bit wrap,
                                     input logic [8:0] bm, input logic [8:0] sm, input int n);
    exp_t e;
    logic [W*H-1:0] b, nx;
    b = cur;
    e.gen = '0;
    e.stable = 1'b0;
    e.cyc = 0;
    for (int i = 0; i < n; i++) begin
      nx = model_step(b, wrap, bm, sm);
      e.gen = e.gen + G'(1);
      if (nx == b) begin
        e.stable = 1'b1;
        break;
      end
      b = nx;
    end
    e.board = b;
    return e;
  endfunction

  function automatic void model_load(input logic [W-1:0] row);
    for (int k = 0; k < 2; k++) mb[k][mptr*W +: W] = row;
    mptr = (mptr + 1) % H;
  endfunction

  // Monitor: every done_o pulse retires one expectation per instance.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (done[k] === 1'b1) begin
        if (sb[k].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done_unexpected[%0d]: got done_o=1, want no pulse", k);
        end else begin
          e = sb[k].pop_front();
          check($sformatf("board[%0d]", k), 64'(board[k]), 64'(e.board));
          check($sformatf("gen_count[%0d]", k), 64'(gen[k]), 64'(e.gen));
          check($sformatf("stable[%0d]", k), 64'(stable[k]), 64'(e.stable));
          check($sformatf("done_cycle[%0d]", k), 64'(cyc), 64'(e.cyc));
          check($sformatf("ready_in_done[%0d]", k), 64'(ready[k]), 64'(0));
        end
      end
    end
  end

  task automatic quiet();
    load_v = 1'b0; start_v = 1'b0; load_row = '0; num_gens = '0; bmask = '0; smask = '0;
  endtask

  task automatic load_one(input logic [W-1:0] row);
    @(negedge clk);
    load_v = 1'b1;
    load_row = row;
    model_load(row);
    @(posedge clk);
    #1 load_v = 1'b0;
  endtask

  task automatic load_board(input logic [W*H-1:0] b);
    for (int r = 0; r < H; r++) load_one(b[r*W +: W]);
  endtask

  task automatic check_board(input string tag);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("%s[%0d]", tag, k), 64'(board[k]), 64'(mb[k]));
  endtask

  task automatic start_run(input int n, input logic [8:0] bm, input logic [8:0] sm,
                           input bit with_load, input logic [W-1:0] row, input bit drain);
    exp_t e;
    bit   drained;
    @(negedge clk);
    if (with_load) model_load(row);
    for (int k = 0; k < 2; k++) begin
      e = model_run(mb[k], k == 1, bm, sm, n);
      e.cyc = cyc + 1 + int'(e.gen);
      sb[k].push_back(e);
      mb[k] = e.board;
    end
    load_v = with_load; load_row = row; start_v = 1'b1;
    num_gens = G'(n); bmask = bm; smask = sm;
    @(posedge clk);
    #1 quiet();
    if (!drain) return;
    drained = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (sb[0].size() == 0 && sb[1].size() == 0) begin
        drained = 1'b1;
        break;
      end
      if (!ready[0] && !ready[1]) begin
        // Load/start/mask activity while both instances are busy must have no effect.
        load_v = 1'($urandom); start_v = 1'($urandom); load_row = W'($urandom);
        num_gens = G'($urandom); bmask = 9'($urandom); smask = 9'($urandom);
      end else begin
        quiet();
      end
    end
    quiet();
    if (!drained) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: got %0d/%0d pending, want 0/0", sb[0].size(), sb[1].size());
      sb[0].delete();
      sb[1].delete();
    end
  endtask

  logic [W*H-1:0] tmp;

  initial begin
    quiet();
    mptr = 0;
    mb[0] = '0;
    mb[1] = '0;
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset_i = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_board[%0d]", k), 64'(board[k]), 64'(0));
      check($sformatf("rst_ready[%0d]", k), 64'(ready[k]), 64'(1));
      check($sformatf("rst_done[%0d]", k), 64'(done[k]), 64'(0));
      check($sformatf("rst_gen[%0d]", k), 64'(gen[k]), 64'(0));
      check($sformatf("rst_stable[%0d]", k), 64'(stable[k]), 64'(0));
    end

    // Blinker, two generations back to the original.
    tmp = '0;
    for (int r = 3; r <= 5; r++) tmp[r*W + 4] = 1'b1;
    load_board(tmp);
    check_board("blinker_load");
    start_run(2, B3, S23, 1'b0, '0, 1'b1);

    // 2x2 block at (2,2): still life after one generation.
    tmp = '0;
    tmp[2*W +: W] = 8'h0C;
    tmp[3*W +: W] = 8'h0C;
    load_board(tmp);
    start_run(10, B3, S23, 1'b0, '0, 1'b1);

    // Glider: returns to its start after 32 generations on the torus.
    tmp = '0;
    tmp[0*W +: W] = 8'h02;
    tmp[1*W +: W] = 8'h04;
    tmp[2*W +: W] = 8'h07;
    load_board(tmp);
    start_run(32, B3, S23, 1'b0, '0, 1'b1);

    // N=0 with a simultaneous row-0 load.
    start_run(0, B3, S23, 1'b1, 8'hA5, 1'b1);
    check_board("n0_load");

    // Nine loads wrap the pointer back onto the first row written.
    for (int i = 0; i < 9; i++) load_one(W'($urandom));
    check_board("load_wrap");

    for (int t = 0; t < 16; t++) begin
      for (int r = 0; r < H; r++) load_one(W'($urandom) & W'($urandom));
      start_run($urandom_range(0, 12), 9'($urandom), 9'($urandom),
                1'($urandom), W'($urandom), 1'b1);
    end
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < H; r++) load_one(W'($urandom));
      start_run($urandom_range(1, 20), B3, S23, 1'b0, '0, 1'b1);
    end

    // Asynchronous reset in the middle of a long run.
    tmp = '0;
    tmp[0*W +: W] = 8'h02;
    tmp[1*W +: W] = 8'h04;
    tmp[2*W +: W] = 8'h07;
    load_board(tmp);
    start_run(60, B3, S23, 1'b0, '0, 1'b0);
    repeat (5) @(negedge clk);
    #3 reset_i = 1'b1;
    #1;
    sb[0].delete();
    sb[1].delete();
    mb[0] = '0;
    mb[1] = '0;
    mptr = 0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrun_board[%0d]", k), 64'(board[k]), 64'(0));
      check($sformatf("midrun_ready[%0d]", k), 64'(ready[k]), 64'(1));
      check($sformatf("midrun_gen[%0d]", k), 64'(gen[k]), 64'(0));
      check($sformatf("midrun_done[%0d]", k), 64'(done[k]), 64'(0));
    end
    repeat (2) @(posedge clk);
    #2 reset_i = 1'b0;
    repeat (3) @(negedge clk);

    // Engine still works after the abort.
    tmp = '0;
    for (int c = 2; c <= 4; c++) tmp[4*W + c] = 1'b1;
    load_board(tmp);
    start_run(3, B3, S23, 1'b0, '0, 1'b1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "simulation time limit");
  end

endmodule
